// File: rtl/rd_stream_packer.sv
// rd_stream_packer
//   Read-data return path from the DDR read-data interface to the C2H
//   AXI-Stream DMA port. Read beats go into a first-word-fall-through FIFO
//   and leave as packets whose tlast boundaries come from a programmable
//   beat count, or from an early close requested with a flush pulse.
//   Free FIFO entries are exported as credits for the read-command
//   scheduler. A beat that arrives while the FIFO is full is dropped and
//   raises a sticky overflow flag.
//
//   Optional feature, macro RD_STREAM_HDR_EN: each packet is preceded by a
//   header beat {.., pkt_len[15:0], pkt_count[31:0]}. The header is
//   generated here and never occupies the FIFO.
//
// Ports
//   clk                clock (DDR user clock)
//   rst                synchronous, active-high reset
//   cfg_pkt_beats      beats per packet, sampled at packet start (0 -> 1)
//   flush              single-cycle pulse, closes the current packet early
//   ddr_rd_data/valid  incoming read beat; there is no backpressure
//   credits            free FIFO entries (DEPTH - occupancy), registered
//   overflow           sticky: a beat was dropped
//   pkt_count          packets completed (tlast handshakes), wraps at 2^32
//   M_AXIS_C2H_*       AXI-Stream master; tkeep is always all ones
module rd_stream_packer #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 64,
  parameter int PKT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PKT_W-1:0]         cfg_pkt_beats,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        ddr_rd_data,
  input  logic                     ddr_rd_valid,
  output logic [$clog2(DEPTH):0]   credits,
  output logic                     overflow,
  output logic [31:0]              pkt_count,
  output logic [DATA_W-1:0]        M_AXIS_C2H_tdata,
  output logic                     M_AXIS_C2H_tvalid,
  output logic [DATA_W/8-1:0]      M_AXIS_C2H_tkeep,
  output logic                     M_AXIS_C2H_tlast,
  input  logic                     M_AXIS_C2H_tready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_tag;            // force_last tag per entry
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_credits;
  logic              r_overflow;
  logic [31:0]       r_pkt_count;
  logic [PKT_W-1:0]  r_beat_cnt;
  logic [PKT_W-1:0]  r_pkt_len;
  logic              r_flush_pending;

  logic              w_empty;
  logic              w_full;
  logic              w_is_hdr;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CW-1:0]     w_count_nxt;
  logic [PKT_W-1:0]  w_cfg_len;
  logic [PKT_W-1:0]  w_cur_len;
  logic              w_latch_len;
  logic              w_data_last;
  logic              w_last_hs;
  logic              w_tag_incoming;
  logic              w_tag_prev;
  logic              w_set_pending;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = !w_empty && M_AXIS_C2H_tready && !w_is_hdr;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign w_push      = ddr_rd_valid && (!w_full || w_pop);
  assign w_drop      = ddr_rd_valid && !w_push;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign w_cfg_len   = (cfg_pkt_beats == '0) ? PKT_W'(1) : cfg_pkt_beats;

`ifdef RD_STREAM_HDR_EN
  typedef enum logic {ST_HDR, ST_DATA} hdr_state_t;

  hdr_state_t        r_state;
  hdr_state_t        w_state_nxt;
  logic [DATA_W-1:0] w_hdr;

  // The length is fixed when the header goes out so that the header and
  // the packet that follows it always agree.
  assign w_is_hdr    = (r_state == ST_HDR);
  assign w_cur_len   = r_pkt_len;
  assign w_latch_len = w_is_hdr && !w_empty && M_AXIS_C2H_tready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_HDR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr       = '0;
    w_hdr[31:0]  = r_pkt_count;
    w_hdr[47:32] = 16'(w_cfg_len);
    case (r_state)
      // The header waits until the first data beat is already buffered.
      ST_HDR:  if (!w_empty && M_AXIS_C2H_tready) w_state_nxt = ST_DATA;
      ST_DATA: if (w_last_hs)                     w_state_nxt = ST_HDR;
      default: w_state_nxt = ST_HDR;
    endcase
  end
`else
  assign w_is_hdr    = 1'b0;
  // On the first beat of a packet the length comes straight from the
  // configuration, and it is captured at that handshake for the rest.
  assign w_cur_len   = (r_beat_cnt == '0) ? w_cfg_len : r_pkt_len;
  assign w_latch_len = w_pop && (r_beat_cnt == '0);
`endif

  // A tag on a beat that is already count-last still yields one tlast.
  assign w_data_last = (r_beat_cnt == w_cur_len - PKT_W'(1)) || r_tag[r_rd_ptr];
  assign w_last_hs   = w_pop && w_data_last;

  // Flush tags the beat arriving now, else the newest buffered beat. When
  // nothing will be left buffered after this cycle's pop, the tag is held
  // pending for the next beat written.
  assign w_tag_incoming = w_push && (flush || r_flush_pending);
  assign w_tag_prev     = flush && !w_push && (w_count_nxt != '0);
  assign w_set_pending  = flush && !w_push && (w_count_nxt == '0);

  // NOTE: storage is not reset; every entry is written (data and tag)
  // before it can reach the head, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ddr_rd_data;
      r_tag[r_wr_ptr] <= w_tag_incoming;
    end else if (w_tag_prev) begin
      r_tag[r_wr_ptr - AW'(1)] <= 1'b1;
    end
  end

  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_credits       <= CW'(DEPTH);
      r_overflow      <= 1'b0;
      r_pkt_count     <= '0;
      r_beat_cnt      <= '0;
      r_pkt_len       <= PKT_W'(1);
      r_flush_pending <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count         <= w_count_nxt;
      r_credits       <= CW'(DEPTH) - w_count_nxt;
      r_overflow      <= r_overflow || w_drop;
      r_flush_pending <= w_set_pending || (r_flush_pending && !w_push);
      if (w_latch_len) r_pkt_len <= w_cfg_len;
      if (w_pop) begin
        if (w_data_last) begin
          r_beat_cnt  <= '0;
          r_pkt_count <= r_pkt_count + 32'd1;
        end else begin
          r_beat_cnt  <= r_beat_cnt + PKT_W'(1);
        end
      end
    end
  end

  // NOTE: every output is given a default first so no latch is inferred.
  always_comb begin
    M_AXIS_C2H_tdata  = '0;
    M_AXIS_C2H_tlast  = 1'b0;
    M_AXIS_C2H_tvalid = !w_empty;
    M_AXIS_C2H_tkeep  = '1;
    if (!w_empty) begin
`ifdef RD_STREAM_HDR_EN
      if (w_is_hdr) begin
        M_AXIS_C2H_tdata = w_hdr;
      end else begin
        M_AXIS_C2H_tdata = r_mem[r_rd_ptr];
        M_AXIS_C2H_tlast = w_data_last;
      end
`else
      M_AXIS_C2H_tdata = r_mem[r_rd_ptr];
      M_AXIS_C2H_tlast = w_data_last;
`endif
    end
  end

  assign credits   = r_credits;
  assign overflow  = r_overflow;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_rd_stream_packer.sv
module tb_rd_stream_packer;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 64;
  localparam int PKT_W  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [PKT_W-1:0]       cfg_pkt_beats = '0;
  logic                   flush = 1'b0;
  logic [DATA_W-1:0]      ddr_rd_data = '0;
  logic                   ddr_rd_valid = 1'b0;
  logic [$clog2(DEPTH):0] credits;
  logic                   overflow;
  logic [31:0]            pkt_count;
  logic [DATA_W-1:0]      tdata;
  logic                   tvalid;
  logic [DATA_W/8-1:0]    tkeep;
  logic                   tlast;
  logic                   tready = 1'b0;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  logic              prev_last  = 1'b0;

  rd_stream_packer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_pkt_beats     (cfg_pkt_beats),
    .flush             (flush),
    .ddr_rd_data       (ddr_rd_data),
    .ddr_rd_valid      (ddr_rd_valid),
    .credits           (credits),
    .overflow          (overflow),
    .pkt_count         (pkt_count),
    .M_AXIS_C2H_tdata  (tdata),
    .M_AXIS_C2H_tvalid (tvalid),
    .M_AXIS_C2H_tkeep  (tkeep),
    .M_AXIS_C2H_tlast  (tlast),
    .M_AXIS_C2H_tready (tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks that a
  // stalled beat is held unchanged into the next cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", DATA_W'(tvalid), DATA_W'(1));
        check("stall_tdata", tdata, prev_data);
        check("stall_tlast", DATA_W'(tlast), DATA_W'(prev_last));
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none (t=%0t)", tdata, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("beat_tdata", tdata, e.data);
          check("beat_tlast", DATA_W'(tlast), DATA_W'(e.last));
          check("beat_tkeep", DATA_W'(tkeep), DATA_W'({(DATA_W/8){1'b1}}));
        end
      end
      prev_stall <= tvalid && !tready;
      prev_data  <= tdata;
      prev_last  <= tlast;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ddr_rd_valid = 1'b0;
      flush        = 1'b0;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    ddr_rd_valid = 1'b1;
    ddr_rd_data  = d;
  endtask

  task automatic expect_beat(input logic [DATA_W-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    ddr_rd_valid = 1'b0;
    flush = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      ddr_rd_valid = 1'b0;
      if (rnd) tready = 1'($urandom_range(0, 1));
      k++;
    end
    tready = 1'b1;
    check("drain_remaining", DATA_W'(sb.size()), '0);
    idle(4);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sent;
    int cyc;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_tvalid", DATA_W'(tvalid), '0);
    check("rst_tlast", DATA_W'(tlast), '0);
    check("rst_tdata", tdata, '0);
    check("rst_tkeep", DATA_W'(tkeep), DATA_W'(8'hFF));
    check("rst_credits", DATA_W'(credits), DATA_W'(DEPTH));
    check("rst_overflow", DATA_W'(overflow), '0);
    check("rst_pkt_count", DATA_W'(pkt_count), '0);

`ifdef RD_STREAM_HDR_EN
    // Headers: {len 2, seq}, then two data beats per packet
    cfg_pkt_beats = 16'd2;
    tready = 1'b1;
    expect_beat(64'h0000_0002_0000_0000, 1'b0);
    expect_beat(64'd0, 1'b0);
    expect_beat(64'd1, 1'b1);
    expect_beat(64'h0000_0002_0000_0001, 1'b0);
    expect_beat(64'd2, 1'b0);
    expect_beat(64'd3, 1'b1);
    for (int i = 0; i < 4; i++) send(DATA_W'(i));
    idle(1);
    wait_drain(200, 1'b0);
    check("hdr_pkt_count", DATA_W'(pkt_count), DATA_W'(2));
`else
    // Two packets of 4 back-to-back, first-beat latency of one cycle
    cfg_pkt_beats = 16'd4;
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_beat(DATA_W'(i), (i == 3) || (i == 7));
      send(DATA_W'(i));
      @(negedge clk);
      if (i == 0) check("lat_before_write", DATA_W'(tvalid), '0);
      if (i == 1) check("lat_after_write", DATA_W'(tvalid), DATA_W'(1));
    end
    idle(1);
    wait_drain(200, 1'b0);
    check("t1_pkt_count", DATA_W'(pkt_count), DATA_W'(2));
    check("t1_credits", DATA_W'(credits), DATA_W'(DEPTH));

    // Flush with two beats buffered closes the packet on the second one
    tready = 1'b0;
    expect_beat(DATA_W'(10), 1'b0);
    expect_beat(DATA_W'(11), 1'b1);
    send(DATA_W'(10));
    send(DATA_W'(11));
    @(posedge clk); #1;
    ddr_rd_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("t2_credits", DATA_W'(credits), DATA_W'(DEPTH - 2));
    check("t2_head_not_last", DATA_W'(tlast), '0);
    @(posedge clk); #1;
    flush = 1'b0;
    tready = 1'b1;
    for (int i = 12; i < 16; i++) begin
      expect_beat(DATA_W'(i), i == 15);
      send(DATA_W'(i));
    end
    idle(1);
    wait_drain(200, 1'b0);
    check("t2_pkt_count", DATA_W'(pkt_count), DATA_W'(4));

    // Flush on an empty FIFO tags the next beat written
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    expect_beat(DATA_W'(20), 1'b1);
    for (int i = 21; i < 25; i++) expect_beat(DATA_W'(i), i == 24);
    for (int i = 20; i < 25; i++) send(DATA_W'(i));
    idle(1);
    wait_drain(200, 1'b0);
    check("t2b_pkt_count", DATA_W'(pkt_count), DATA_W'(6));

    // Fill to overflow with cfg 0 (one-beat packets)
    do_reset();
    cfg_pkt_beats = '0;
    tready = 1'b0;
    for (int i = 0; i < 65; i++) begin
      if (i < 64) expect_beat(DATA_W'(100 + i), 1'b1);
      send(DATA_W'(100 + i));
      @(negedge clk);
      check("t3_credits_step", DATA_W'(credits), DATA_W'(DEPTH - i));
    end
    idle(1);
    @(negedge clk);
    check("t3_credits_full", DATA_W'(credits), '0);
    check("t3_overflow_set", DATA_W'(overflow), DATA_W'(1));
    tready = 1'b1;
    wait_drain(400, 1'b0);
    check("t3_overflow_sticky", DATA_W'(overflow), DATA_W'(1));
    check("t3_pkt_count", DATA_W'(pkt_count), DATA_W'(64));
    check("t3_credits_empty", DATA_W'(credits), DATA_W'(DEPTH));

    // Reset with 10 beats buffered mid-packet
    cfg_pkt_beats = 16'd4;
    tready = 1'b0;
    for (int i = 0; i < 10; i++) send(DATA_W'(200 + i));
    idle(1);
    @(negedge clk);
    check("t4_credits_buf", DATA_W'(credits), DATA_W'(DEPTH - 10));
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t4_tvalid", DATA_W'(tvalid), '0);
    check("t4_credits", DATA_W'(credits), DATA_W'(DEPTH));
    check("t4_pkt_count", DATA_W'(pkt_count), '0);
    check("t4_overflow", DATA_W'(overflow), '0);
    cfg_pkt_beats = 16'd3;
    tready = 1'b1;
    expect_beat(DATA_W'(300), 1'b0);
    expect_beat(DATA_W'(301), 1'b0);
    expect_beat(DATA_W'(302), 1'b1);
    for (int i = 0; i < 3; i++) send(DATA_W'(300 + i));
    idle(1);
    wait_drain(200, 1'b0);
    check("t4_new_pkt_count", DATA_W'(pkt_count), DATA_W'(1));

    // 1000 beats, random tready, packets of 7 (final 6 beats stay open)
    cfg_pkt_beats = 16'd7;
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      tready = 1'($urandom_range(0, 1));
      cyc++;
      if (credits > 2) begin
        ddr_rd_valid = 1'b1;
        ddr_rd_data  = 64'hA5A5_0000_0000_0000 | DATA_W'(sent);
        expect_beat(64'hA5A5_0000_0000_0000 | DATA_W'(sent), (sent % 7) == 6);
        sent++;
      end else begin
        ddr_rd_valid = 1'b0;
      end
    end
    check("t5_beats_sent", DATA_W'(sent), DATA_W'(1000));
    idle(1);
    wait_drain(10000, 1'b1);
    check("t5_pkt_count", DATA_W'(pkt_count), DATA_W'(1 + 142));
    check("t5_overflow", DATA_W'(overflow), '0);
    check("t5_credits", DATA_W'(credits), DATA_W'(DEPTH));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rd_stream_packer.md
Name: rd_stream_packer

Overview:
- Parametrised read-data return path between the DDR read-data interface (ddr_rd_data/ddr_rd_valid) and the C2H AXI-Stream DMA port.
- Buffers read beats in a FIFO and packetises them with programmable tlast boundaries.
- Exports a credit count so the command scheduler never issues more reads than the buffer can hold, and flags overflow.
- Sits inside the core, replacing the fixed-width direct read-data forwarding.

Parameters:
- DATA_W, 512, beat width; must be a multiple of 8.
- DEPTH, 64, FIFO entries; must be a power of two, at least 4.
- PKT_W, 16, width of the packet-length configuration.

Ports:
- clk  in  1  DDR user clock.
- rst  in  1  synchronous, active-high reset.
- cfg_pkt_beats  in  PKT_W  beats per packet; sampled at each packet start; 0 treated as 1.
- flush  in  1  single-cycle pulse; closes the current packet early.
- ddr_rd_data  in  DATA_W  read beat.
- ddr_rd_valid  in  1  beat valid; no backpressure.
- credits  out  $clog2(DEPTH)+1  free FIFO entries.
- overflow  out  1  sticky; a beat was dropped.
- pkt_count  out  32  completed packets (tlast handshakes).
- M_AXIS_C2H_tdata  out  DATA_W  stream data.
- M_AXIS_C2H_tvalid  out  1  stream valid.
- M_AXIS_C2H_tkeep  out  DATA_W/8  byte enables.
- M_AXIS_C2H_tlast  out  1  packet end.
- M_AXIS_C2H_tready  in  1  DMA ready.

Behaviour:
- Clocking and reset:
  - Single clock clk; reset is synchronous and active-high on rst.
  - While rst is high: FIFO emptied, tvalid=0, tlast=0, tkeep=all ones, tdata=0, credits=DEPTH, overflow=0, pkt_count=0, beat_cnt=0, flush_pending=0.
  - Reset mid-packet discards all buffered data. No partial packet is completed.
- FIFO:
  - First-word-fall-through; each entry holds data plus one force_last tag bit.
  - Write occurs when ddr_rd_valid=1 and the FIFO is not full.
  - A write occurring in the same cycle as a read while full is accepted.
  - Beat valid at edge N appears on tdata with tvalid=1 after edge N+1, i.e. 1-cycle latency when empty.
  - Full with no concurrent read: the beat is dropped and overflow is set until rst.
- Credits:
  - credits = DEPTH - occupancy, registered, updated every cycle.
  - Simultaneous push and pop leaves credits unchanged.
- Handshake:
  - Standard AXIS: tdata, tlast and tkeep are held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - tkeep is constant all ones.
- Packetisation:
  - beat_cnt counts handshaken beats within a packet.
  - pkt_len is latched from cfg_pkt_beats when beat_cnt=0 at the first handshake of a packet.
  - tlast = (beat_cnt == pkt_len-1) OR force_last tag of the head entry.
  - On a tlast handshake: beat_cnt returns to 0 and pkt_count increments, wrapping modulo 2^32.
  - cfg_pkt_beats changes mid-packet take effect at the next packet.
- Flush:
  - With a write in the same cycle: the incoming beat is tagged.
  - Else, if the FIFO is non-empty: the most recently written entry is tagged.
  - Else: flush_pending is set and the next written beat is tagged, then flush_pending clears.
  - Flush while flush_pending is already set has no additional effect.
  - A tag on a beat that is already count-last yields a single tlast.

Optional Feature:
- Macro: RD_STREAM_HDR_EN.
- When defined, each packet is preceded by a header beat before its first data beat. The header beat has:
  - tdata[31:0] = pkt_count value at emission;
  - tdata[47:32] = latched pkt_len, zero-extended or truncated to 16 bits;
  - all other bits 0, tkeep all ones, tlast=0.
- The header beat is not counted in beat_cnt and does not occupy the FIFO.
- It is emitted only once the first data beat of the packet is present in the FIFO, then that data beat follows. This adds a 2-state sequencer HDR/DATA.
- When undefined, no header is emitted and output is exactly as above.

Test Plan:
- Reset, then cfg_pkt_beats=4, 8 back-to-back beats 0..7, tready=1:
  - two packets, tlast on beats 3 and 7;
  - pkt_count=2;
  - first tvalid 1 cycle after first valid.
- cfg=4, 2 beats, then flush pulse with FIFO non-empty:
  - beat 1 carries tlast;
  - next 4 beats form a full packet.
- DEPTH=64, tready=0, 65 beats:
  - credits steps 64→0;
  - beat 65 dropped, overflow=1;
  - after tready=1, exactly 64 beats out, overflow stays 1 until rst.
- Random tready (50%), 1000 beats, cfg=7:
  - data order preserved;
  - payload stable under stall;
  - tlast every 7th beat, last partial packet has no tlast.
- Assert rst mid-packet with 10 buffered beats:
  - next cycle tvalid=0, credits=DEPTH, pkt_count=0;
  - new packet starts with beat_cnt=0.
- RD_STREAM_HDR_EN, cfg=2, 4 beats:
  - output sequence header(seq 0, len 2), D0, D1(last), header(seq 1), D2, D3(last).
